enemy_wave_controller: RTL and testbench
========================================

# enemy_wave_controller

Parametrised multi-lane enemy spawner and combat tracker running on the game's slow tick (`slow_clk`, about 3 Hz). It manages NUM_LANES independent view directions. Each lane spawns enemies on a staggered schedule, tracks their health, takes hits from the weapon path, and issues periodic attack pulses. It publishes presence, health, kill count and a wave-cleared status to the renderer and the player-health logic. Unlike the fixed three-direction controller, it adds per-lane health outputs, a pause input, a kill counter, a wave-cleared terminal state and restart.

## Interface
- NUM_LANES, 3, number of view directions; lane index 0..NUM_LANES-1.
- HEALTH_W, 2, width of the health field.
- BASE_HEALTH, 2, health of a fresh enemy; must be 1..2^HEALTH_W-1.
- MAX_PER_LANE, 3, total enemies spawned per lane per wave; must be ≥1.
- TIMER_W, 6, width of the spawn and attack timers.
- FIRST_DELAY_BASE, 6, ticks from wave start to the first spawn in lane 0.
- FIRST_DELAY_STEP, 9, extra first-spawn delay per lane index.
- RESPAWN_DELAY, 15, ticks from a kill to the next spawn in the same lane.
- ATTACK_PERIOD, 6, ticks between attacks of a live enemy.
- LANE_W = max(1, clog2(NUM_LANES)); KILL_W = clog2(NUM_LANES*MAX_PER_LANE+1). Both are derived, not overridable.

Ports:
- slow_clk, in, 1, game tick clock.
- rst, in, 1, reset, asynchronous, active-high.
- start, in, 1, level; sampled in IDLE/CLEARED to begin a wave.
- pause, in, 1, freezes all timers and ignores hits while high.
- hit_valid, in, 1, one-tick pulse: the weapon fired this tick.
- hit_lane, in, LANE_W, lane the player is facing during the hit.
- state, out, 2, IDLE=00, RUN=01, CLEARED=10.
- enemy_present, out, NUM_LANES, bit i = live enemy in lane i.
- enemy_health, out, NUM_LANES*HEALTH_W, lane i occupies bits [i*HEALTH_W +: HEALTH_W]; 0 when absent.
- attack_lanes, out, NUM_LANES, one-tick per-lane attack pulses.
- attack_pulse, out, 1, OR of attack_lanes (registered, same cycle).
- kill_count, out, KILL_W, kills in the current wave.
- all_cleared, out, 1, high while state==CLEARED.

## Operation
- Top FSM:
  - IDLE, on start → RUN. All lanes load WAIT_FIRST with timer=0, and kill_count clears.
  - RUN, when all lanes are DONE → CLEARED.
  - CLEARED, on start → RUN, same initialisation as from IDLE.
  - start is ignored while in RUN.
- Lane FSM (per lane i):
  - WAIT_FIRST: delay D_i = FIRST_DELAY_BASE + i*FIRST_DELAY_STEP.
  - WAIT_RESPAWN: delay RESPAWN_DELAY.
  - ALIVE.
  - DONE.
- Wait states: the timer increments on each unpaused tick. On the tick where timer==delay-1 and !pause, the next edge:
  - goes to ALIVE, present=1, health=BASE_HEALTH;
  - increments the spawned count; attack timer=0.
- ALIVE hit: hit_valid && hit_lane==i && !pause decrements health by 1.
  - If health was 1: present=0, health=0, kill_count+1.
  - Then go to DONE if spawned==MAX_PER_LANE, else WAIT_RESPAWN with timer=0.
- hit_lane ≥ NUM_LANES is ignored. A hit on a lane not ALIVE is ignored.
- ALIVE attack: the attack timer increments on unpaused ticks. When it reaches ATTACK_PERIOD-1, the next edge pulses attack_lanes[i] for one tick and the timer returns to 0.
- A kill and an attack due on the same tick: the kill wins, no pulse.
- A hit that does not kill does not reset the attack timer.
- pause high: all state, timers and outputs hold; attack_lanes=0.
- Width rules:
  - Timers saturate at all-ones. Elaboration error if any delay exceeds 2^TIMER_W-1.
  - kill_count never wraps, because its width covers the maximum kill count.

## Timing
- Every output is registered. There is no combinational path from inputs to outputs.
- Reset values: state=IDLE, enemy_present=0, enemy_health=0, attack_lanes=0, attack_pulse=0, kill_count=0, all_cleared=0. Lanes are in DONE (inactive), and timers are 0.
- Start accepted at edge t (state=RUN after t) → lane i present after edge t+D_i.
- A killing hit sampled at edge t → enemy_present[i]=0 after edge t. The next spawn follows after edge t+RESPAWN_DELAY.
- The first attack comes ATTACK_PERIOD ticks after the spawn edge.
- The transition to CLEARED occurs on the edge after the last lane enters DONE.
- rst mid-wave returns to reset values immediately (asynchronous). Synchronous release is handled by the top-level reset synchroniser.

## Structure
- Shared package game_pkg holds:
  - the top-state encodings (IDLE/RUN/CLEARED);
  - the lane-state encodings (WAIT_FIRST, WAIT_RESPAWN, ALIVE, DONE);
  - the weapon FIRE code and the camera-view-to-lane mapping constants used by the upstream adapter.
- Sub-module enemy_lane: one lane FSM with its timers, health and spawned count. It is instantiated NUM_LANES times in a generate loop, with its delay passed as a parameter.
- The top level holds the top FSM, the kill counter, the hit decoder, and the attack OR and reduction.

## Test plan
- Defaults, start at tick 0 → lanes 0/1/2 present after ticks 6/15/24, each with health 2; attack_pulse at ticks 12/21/30.
- Two hits on lane 0 at ticks 8 and 9 → health 2→1→0, present drops after tick 9, kill_count=1, lane 0 respawns after tick 24.
- Kill every enemy as it spawns → after 9 kills all lanes are DONE, state=CLEARED, all_cleared=1; start → RUN, kill_count=0, schedule repeats.
- Lane 0 kill coinciding with a due attack → no attack_lanes[0] pulse, kill counted.
- pause held for 10 ticks mid-wait → spawn delayed by exactly 10 ticks; hits during pause are ignored.
- hit_lane=3 with NUM_LANES=3, and rst asserted mid-RUN → no state change; then all outputs return to reset values immediately.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game encodings: top/lane FSM states, weapon fire code and
// camera-view-to-lane mapping used by the upstream adapter.
package game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_RUN     = 2'b01,
      ST_CLEARED = 2'b10
   } top_state_e;

   typedef enum logic [1:0] {
      LN_WAIT_FIRST   = 2'b00,
      LN_WAIT_RESPAWN = 2'b01,
      LN_ALIVE        = 2'b10,
      LN_DONE         = 2'b11
   } lane_state_e;

   localparam logic [1:0] WEAPON_FIRE       = 2'b01;
   localparam logic [1:0] VIEW_LEFT_LANE    = 2'd0;
   localparam logic [1:0] VIEW_CENTER_LANE  = 2'd1;
   localparam logic [1:0] VIEW_RIGHT_LANE   = 2'd2;

   // Largest value a saturating timer of width w can hold.
   function automatic int max_timer_value(input int w);
      return (1 << w) - 1;
   endfunction

endpackage

// File: rtl/enemy_lane.sv
// One view-direction lane: spawn scheduling, health, spawned count and the
// attack cadence of the live enemy.
module enemy_lane
   import game_pkg::*;
#(
   parameter int HEALTH_W      = 2,
   parameter int BASE_HEALTH   = 2,
   parameter int MAX_PER_LANE  = 3,
   parameter int TIMER_W       = 6,
   parameter int FIRST_DELAY   = 6,
   parameter int RESPAWN_DELAY = 15,
   parameter int ATTACK_PERIOD = 6
) (
   input  logic                slow_clk,
   input  logic                rst,
   input  logic                init,
   input  logic                pause,
   input  logic                hit,
   output logic                present,
   output logic [HEALTH_W-1:0] health,
   output logic                attack_due,
   output logic                kill,
   output logic                done
);

   localparam int SPAWN_W = $clog2(MAX_PER_LANE + 1);
   localparam logic [TIMER_W-1:0]  FIRST_LAST   = TIMER_W'(FIRST_DELAY - 1);
   localparam logic [TIMER_W-1:0]  RESPAWN_LAST = TIMER_W'(RESPAWN_DELAY - 1);
   localparam logic [TIMER_W-1:0]  ATTACK_LAST  = TIMER_W'(ATTACK_PERIOD - 1);
   localparam logic [SPAWN_W-1:0]  SPAWN_MAX    = SPAWN_W'(MAX_PER_LANE);
   localparam logic [HEALTH_W-1:0] HEALTH_FULL  = HEALTH_W'(BASE_HEALTH);

   lane_state_e         lane_state_r, lane_state_s;
   logic [TIMER_W-1:0]  wait_timer_r, wait_timer_s;
   logic [TIMER_W-1:0]  atk_timer_r, atk_timer_s;
   logic [TIMER_W-1:0]  wait_last_s;
   logic [SPAWN_W-1:0]  spawned_r, spawned_s;
   logic                present_r, present_s;
   logic [HEALTH_W-1:0] health_r, health_s;
   logic                kill_s, attack_due_s;

   function automatic logic [TIMER_W-1:0] sat_inc(input logic [TIMER_W-1:0] v);
      return (&v) ? v : v + TIMER_W'(1);
   endfunction

   assign wait_last_s = (lane_state_r == LN_WAIT_FIRST) ? FIRST_LAST : RESPAWN_LAST;

   // Lane next-state: wave init, spawn timing, hit/kill and attack cadence.
   always_comb begin
      lane_state_s = lane_state_r;
      wait_timer_s = wait_timer_r;
      atk_timer_s  = atk_timer_r;
      spawned_s    = spawned_r;
      present_s    = present_r;
      health_s     = health_r;
      kill_s       = 1'b0;
      attack_due_s = 1'b0;
      if (init) begin
         lane_state_s = LN_WAIT_FIRST;
         wait_timer_s = {TIMER_W{1'b0}};
         atk_timer_s  = {TIMER_W{1'b0}};
         spawned_s    = {SPAWN_W{1'b0}};
         present_s    = 1'b0;
         health_s     = {HEALTH_W{1'b0}};
      end else if (pause) begin
         lane_state_s = lane_state_r;
      end else begin
         case (lane_state_r)
            LN_WAIT_FIRST, LN_WAIT_RESPAWN: begin
               if (wait_timer_r == wait_last_s) begin
                  lane_state_s = LN_ALIVE;
                  present_s    = 1'b1;
                  health_s     = HEALTH_FULL;
                  spawned_s    = spawned_r + SPAWN_W'(1);
                  atk_timer_s  = {TIMER_W{1'b0}};
               end else begin
                  wait_timer_s = sat_inc(wait_timer_r);
               end
            end
            LN_ALIVE: begin
               if (hit && (health_r == HEALTH_W'(1))) begin
                  // a kill pre-empts any attack due on the same tick
                  kill_s       = 1'b1;
                  present_s    = 1'b0;
                  health_s     = {HEALTH_W{1'b0}};
                  wait_timer_s = {TIMER_W{1'b0}};
                  if (spawned_r == SPAWN_MAX) begin
                     lane_state_s = LN_DONE;
                  end else begin
                     lane_state_s = LN_WAIT_RESPAWN;
                  end
               end else begin
                  if (hit) begin
                     health_s = health_r - HEALTH_W'(1);
                  end else begin
                     health_s = health_r;
                  end
                  if (atk_timer_r == ATTACK_LAST) begin
                     attack_due_s = 1'b1;
                     atk_timer_s  = {TIMER_W{1'b0}};
                  end else begin
                     atk_timer_s = sat_inc(atk_timer_r);
                  end
               end
            end
            LN_DONE: begin
               lane_state_s = LN_DONE;
            end
            default: begin
               lane_state_s = LN_DONE;
            end
         endcase
      end
   end

   // Lane state registers; reset parks the lane inactive in DONE.
   always_ff @(posedge slow_clk or posedge rst) begin
      if (rst) begin
         lane_state_r <= LN_DONE;
         wait_timer_r <= {TIMER_W{1'b0}};
         atk_timer_r  <= {TIMER_W{1'b0}};
         spawned_r    <= {SPAWN_W{1'b0}};
         present_r    <= 1'b0;
         health_r     <= {HEALTH_W{1'b0}};
      end else begin
         lane_state_r <= lane_state_s;
         wait_timer_r <= wait_timer_s;
         atk_timer_r  <= atk_timer_s;
         spawned_r    <= spawned_s;
         present_r    <= present_s;
         health_r     <= health_s;
      end
   end

   assign present    = present_r;
   assign health     = health_r;
   assign attack_due = attack_due_s;
   assign kill       = kill_s;
   assign done       = (lane_state_r == LN_DONE);

endmodule

// File: rtl/enemy_wave_controller.sv
// Multi-lane enemy spawner and combat tracker: wave FSM, hit decode, kill
// counter and registered attack/presence outputs for renderer and health logic.
module enemy_wave_controller
   import game_pkg::*;
#(
   parameter int NUM_LANES        = 3,
   parameter int HEALTH_W         = 2,
   parameter int BASE_HEALTH      = 2,
   parameter int MAX_PER_LANE     = 3,
   parameter int TIMER_W          = 6,
   parameter int FIRST_DELAY_BASE = 6,
   parameter int FIRST_DELAY_STEP = 9,
   parameter int RESPAWN_DELAY    = 15,
   parameter int ATTACK_PERIOD    = 6,
   localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
   localparam int KILL_W = $clog2(NUM_LANES * MAX_PER_LANE + 1)
) (
   input  logic                          slow_clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          pause,
   input  logic                          hit_valid,
   input  logic [LANE_W-1:0]             hit_lane,
   output logic [1:0]                    state,
   output logic [NUM_LANES-1:0]          enemy_present,
   output logic [NUM_LANES*HEALTH_W-1:0] enemy_health,
   output logic [NUM_LANES-1:0]          attack_lanes,
   output logic                          attack_pulse,
   output logic [KILL_W-1:0]             kill_count,
   output logic                          all_cleared
);

   localparam int TIMER_MAX  = max_timer_value(TIMER_W);
   localparam int LAST_FIRST = FIRST_DELAY_BASE + (NUM_LANES - 1) * FIRST_DELAY_STEP;

   if ((BASE_HEALTH < 1) || (BASE_HEALTH > (1 << HEALTH_W) - 1) || (MAX_PER_LANE < 1) ||
       (FIRST_DELAY_BASE < 1) || (RESPAWN_DELAY < 1) || (ATTACK_PERIOD < 1) ||
       (LAST_FIRST > TIMER_MAX) || (RESPAWN_DELAY > TIMER_MAX) || (ATTACK_PERIOD > TIMER_MAX))
   begin : g_cfg_err
      $error("enemy_wave_controller: health or delay parameter out of range");
   end

   top_state_e           state_r, state_s;
   logic                 init_s;
   logic [NUM_LANES-1:0] hit_vec_s, present_s, attack_due_s, kill_s, done_s;
   logic [NUM_LANES-1:0] attack_lanes_r;
   logic                 attack_pulse_r, all_cleared_r;
   logic [KILL_W-1:0]    kill_count_r;

   // Wave FSM: start launches a wave from IDLE/CLEARED; all lanes DONE ends it.
   always_comb begin
      state_s = state_r;
      init_s  = 1'b0;
      case (state_r)
         ST_IDLE, ST_CLEARED: begin
            if (start && !pause) begin
               init_s  = 1'b1;
               state_s = ST_RUN;
            end else begin
               state_s = state_r;
            end
         end
         ST_RUN: begin
            if ((&done_s) && !pause) begin
               state_s = ST_CLEARED;
            end else begin
               state_s = state_r;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Hit decoder; out-of-range lane indices match no lane.
   always_comb begin
      hit_vec_s = {NUM_LANES{1'b0}};
      for (int i = 0; i < NUM_LANES; i++) begin
         hit_vec_s[i] = hit_valid && !pause && (hit_lane == LANE_W'(i));
      end
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      enemy_lane #(
         .HEALTH_W      (HEALTH_W),
         .BASE_HEALTH   (BASE_HEALTH),
         .MAX_PER_LANE  (MAX_PER_LANE),
         .TIMER_W       (TIMER_W),
         .FIRST_DELAY   (FIRST_DELAY_BASE + i * FIRST_DELAY_STEP),
         .RESPAWN_DELAY (RESPAWN_DELAY),
         .ATTACK_PERIOD (ATTACK_PERIOD)
      ) u_lane (
         .slow_clk   (slow_clk),
         .rst        (rst),
         .init       (init_s),
         .pause      (pause),
         .hit        (hit_vec_s[i]),
         .present    (present_s[i]),
         .health     (enemy_health[i*HEALTH_W +: HEALTH_W]),
         .attack_due (attack_due_s[i]),
         .kill       (kill_s[i]),
         .done       (done_s[i])
      );
   end

   // Wave state, kill counter and attack outputs, all registered.
   always_ff @(posedge slow_clk or posedge rst) begin
      if (rst) begin
         state_r        <= ST_IDLE;
         attack_lanes_r <= {NUM_LANES{1'b0}};
         attack_pulse_r <= 1'b0;
         kill_count_r   <= {KILL_W{1'b0}};
         all_cleared_r  <= 1'b0;
      end else begin
         state_r        <= state_s;
         attack_lanes_r <= attack_due_s;
         attack_pulse_r <= |attack_due_s;
         all_cleared_r  <= (state_s == ST_CLEARED);
         if (init_s) begin
            kill_count_r <= {KILL_W{1'b0}};
         end else if (|kill_s) begin
            kill_count_r <= kill_count_r + KILL_W'(1);
         end else begin
            kill_count_r <= kill_count_r;
         end
      end
   end

   assign state         = state_r;
   assign enemy_present = present_s;
   assign attack_lanes  = attack_lanes_r;
   assign attack_pulse  = attack_pulse_r;
   assign kill_count    = kill_count_r;
   assign all_cleared   = all_cleared_r;

endmodule

// File: tb/tb_enemy_wave_controller.sv
// Scoreboard bench for enemy_wave_controller: directed waves push expected
// snapshots/attack events; negedge and reset monitors pop and compare.
module tb_enemy_wave_controller;

   localparam int NL = 3;
   localparam int HW = 2;
   localparam int LW = 2;
   localparam int KW = 4;

   logic          slow_clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          pause = 1'b0;
   logic          hit_valid = 1'b0;
   logic [LW-1:0] hit_lane = 2'd0;
   logic [1:0]    state;
   logic [NL-1:0] enemy_present, attack_lanes;
   logic [NL*HW-1:0] enemy_health;
   logic          attack_pulse;
   logic [KW-1:0] kill_count;
   logic          all_cleared;

   enemy_wave_controller dut (
      .slow_clk      (slow_clk),
      .rst           (rst),
      .start         (start),
      .pause         (pause),
      .hit_valid     (hit_valid),
      .hit_lane      (hit_lane),
      .state         (state),
      .enemy_present (enemy_present),
      .enemy_health  (enemy_health),
      .attack_lanes  (attack_lanes),
      .attack_pulse  (attack_pulse),
      .kill_count    (kill_count),
      .all_cleared   (all_cleared)
   );

   always #5 slow_clk = ~slow_clk;

   int edge_n = 0;
   always @(posedge slow_clk) edge_n <= edge_n + 1;

   typedef enum int {K_STATE, K_PRESENT, K_HEALTH, K_KILL, K_CLEARED, K_ATK_LANES, K_ATK_PULSE} kind_e;
   typedef struct {int at; kind_e kind; logic [31:0] val; string name;} exp_t;
   typedef struct {int at; logic [2:0] lanes;} atk_t;
   typedef enum int {E_HIT, E_PAUSE_ON, E_PAUSE_OFF, E_START} ev_kind_e;
   typedef struct {int t; ev_kind_e kind; int lane;} ev_t;

   exp_t sb_q[$];
   atk_t atk_q[$];
   ev_t  ev_q[$];
   int   atk_lo = -1;
   int   atk_hi = -2;
   int   total = 0;
   int   bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   function automatic logic [31:0] observe(input kind_e k);
      case (k)
         K_STATE:     return {30'd0, state};
         K_PRESENT:   return {29'd0, enemy_present};
         K_HEALTH:    return {26'd0, enemy_health};
         K_KILL:      return {28'd0, kill_count};
         K_CLEARED:   return {31'd0, all_cleared};
         K_ATK_LANES: return {29'd0, attack_lanes};
         K_ATK_PULSE: return {31'd0, attack_pulse};
         default:     return 32'hdead_beef;
      endcase
   endfunction

   // Snapshot and attack-event monitor, sampled away from the active edge.
   always @(negedge slow_clk) begin
      atk_t a;
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
         if (sb_q[i].at == edge_n) begin
            check(sb_q[i].name, observe(sb_q[i].kind), sb_q[i].val);
            sb_q.delete(i);
         end else if (sb_q[i].at < edge_n) begin
            total++;
            bad++;
            $display("FAIL %s: expectation for edge %0d never sampled", sb_q[i].name, sb_q[i].at);
            sb_q.delete(i);
         end
      end
      if (edge_n >= atk_lo && edge_n <= atk_hi) begin
         if (attack_pulse !== 1'b0 || attack_lanes !== 3'b000) begin
            if (atk_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL attack_unexpected: lanes %b at edge %0d, none expected", attack_lanes, edge_n);
            end else begin
               a = atk_q.pop_front();
               check("attack_edge", edge_n, a.at);
               check("attack_lanes_ev", {29'd0, attack_lanes}, {29'd0, a.lanes});
               check("attack_pulse_ev", {31'd0, attack_pulse}, 32'd1);
            end
         end
         if (edge_n == atk_hi) check("attack_pending", atk_q.size(), 32'd0);
      end
   end

   // Asynchronous reset monitor: outputs must be at reset values at once.
   always @(posedge rst) begin
      #1;
      check("rst_state",        {30'd0, state},         32'd0);
      check("rst_present",      {29'd0, enemy_present}, 32'd0);
      check("rst_health",       {26'd0, enemy_health},  32'd0);
      check("rst_attack_lanes", {29'd0, attack_lanes},  32'd0);
      check("rst_attack_pulse", {31'd0, attack_pulse},  32'd0);
      check("rst_kill",         {28'd0, kill_count},    32'd0);
      check("rst_cleared",      {31'd0, all_cleared},   32'd0);
   end

   task automatic next_tick();
      @(negedge slow_clk);
      #1;
   endtask

   task automatic wait_until(input int e);
      while (edge_n < e) next_tick();
   endtask

   task automatic expect_at(input int e, input kind_e k, input logic [31:0] v, input string n);
      exp_t x;
      x.at = e; x.kind = k; x.val = v; x.name = n;
      sb_q.push_back(x);
   endtask

   task automatic add_ev(input int t, input ev_kind_e k, input int l);
      ev_t x;
      x.t = t; x.kind = k; x.lane = l;
      ev_q.push_back(x);
   endtask

   task automatic add_atk(input int e, input logic [2:0] l);
      atk_t x;
      x.at = e; x.lanes = l;
      atk_q.push_back(x);
   endtask

   // Each event acts on edge t0+t (inputs driven after the preceding negedge).
   task automatic run_events(input int t0);
      ev_t ev;
      while (ev_q.size() > 0) begin
         ev = ev_q.pop_front();
         wait_until(t0 + ev.t - 1);
         case (ev.kind)
            E_HIT: begin
               hit_lane = LW'(ev.lane);
               hit_valid = 1'b1;
               next_tick();
               hit_valid = 1'b0;
            end
            E_START: begin
               start = 1'b1;
               next_tick();
               start = 1'b0;
            end
            E_PAUSE_ON:  pause = 1'b1;
            E_PAUSE_OFF: pause = 1'b0;
            default:     pause = 1'b0;
         endcase
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      next_tick();
      start = 1'b0;
   endtask

   task automatic pulse_rst();
      #2;
      rst = 1'b1;
      next_tick();
      next_tick();
      rst = 1'b0;
      next_tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t0;
      int hl[18];
      int ht[18];
      #1 rst = 1'b1;
      next_tick();
      next_tick();
      rst = 1'b0;
      next_tick();

      // Wave 1: schedule, attack cadence, ignored hits, start ignored in RUN.
      t0 = edge_n + 1;
      expect_at(t0,      K_STATE,   32'd1, "w1_state_run");
      expect_at(t0,      K_KILL,    32'd0, "w1_kill0");
      expect_at(t0 + 5,  K_PRESENT, 32'b000, "w1_pres5");
      expect_at(t0 + 6,  K_PRESENT, 32'b001, "w1_pres6");
      expect_at(t0 + 6,  K_HEALTH,  32'b000010, "w1_hp6");
      expect_at(t0 + 10, K_HEALTH,  32'b000010, "w1_lane3_ignored");
      expect_at(t0 + 11, K_PRESENT, 32'b001, "w1_dead_lane_hit_pres");
      expect_at(t0 + 11, K_HEALTH,  32'b000010, "w1_dead_lane_hit_hp");
      expect_at(t0 + 14, K_PRESENT, 32'b001, "w1_pres14");
      expect_at(t0 + 15, K_PRESENT, 32'b011, "w1_pres15");
      expect_at(t0 + 15, K_HEALTH,  32'b001010, "w1_hp15");
      expect_at(t0 + 23, K_PRESENT, 32'b011, "w1_pres23");
      expect_at(t0 + 24, K_PRESENT, 32'b111, "w1_pres24");
      expect_at(t0 + 24, K_HEALTH,  32'b101010, "w1_hp24");
      expect_at(t0 + 26, K_STATE,   32'd1, "w1_start_in_run");
      expect_at(t0 + 27, K_PRESENT, 32'b111, "w1_pres27");
      expect_at(t0 + 27, K_HEALTH,  32'b101010, "w1_hp27");
      add_atk(t0 + 12, 3'b001);
      add_atk(t0 + 18, 3'b001);
      add_atk(t0 + 21, 3'b010);
      add_atk(t0 + 24, 3'b001);
      add_atk(t0 + 27, 3'b010);
      add_atk(t0 + 30, 3'b101);
      atk_lo = t0;
      atk_hi = t0 + 31;
      add_ev(10, E_HIT, 3);
      add_ev(11, E_HIT, 1);
      add_ev(26, E_START, 0);
      pulse_start();
      run_events(t0);
      wait_until(t0 + 33);
      pulse_rst();

      // Wave 2: kill/respawn, kill beats attack, non-kill hit keeps cadence, pause.
      t0 = edge_n + 1;
      expect_at(t0,      K_STATE,     32'd1, "w2_state_run");
      expect_at(t0,      K_KILL,      32'd0, "w2_kill0");
      expect_at(t0 + 6,  K_PRESENT,   32'b001, "w2_pres6");
      expect_at(t0 + 8,  K_HEALTH,    32'b000001, "w2_hp8");
      expect_at(t0 + 8,  K_PRESENT,   32'b001, "w2_pres8");
      expect_at(t0 + 9,  K_PRESENT,   32'b000, "w2_pres9");
      expect_at(t0 + 9,  K_HEALTH,    32'b000000, "w2_hp9");
      expect_at(t0 + 9,  K_KILL,      32'd1, "w2_kill9");
      expect_at(t0 + 15, K_PRESENT,   32'b010, "w2_pres15");
      expect_at(t0 + 15, K_HEALTH,    32'b001000, "w2_hp15");
      expect_at(t0 + 23, K_PRESENT,   32'b010, "w2_pres23");
      expect_at(t0 + 24, K_PRESENT,   32'b111, "w2_respawn24");
      expect_at(t0 + 24, K_HEALTH,    32'b101010, "w2_hp24");
      expect_at(t0 + 29, K_HEALTH,    32'b101001, "w2_hp29");
      expect_at(t0 + 29, K_ATK_LANES, 32'b000, "w2_atk29");
      expect_at(t0 + 30, K_ATK_LANES, 32'b100, "w2_kill_beats_attack");
      expect_at(t0 + 30, K_ATK_PULSE, 32'd1, "w2_pulse30");
      expect_at(t0 + 30, K_KILL,      32'd2, "w2_kill30");
      expect_at(t0 + 30, K_PRESENT,   32'b110, "w2_pres30");
      expect_at(t0 + 30, K_HEALTH,    32'b101000, "w2_hp30");
      expect_at(t0 + 31, K_ATK_LANES, 32'b000, "w2_atk31");
      expect_at(t0 + 32, K_HEALTH,    32'b100100, "w2_hp32");
      expect_at(t0 + 33, K_ATK_LANES, 32'b010, "w2_hit_keeps_cadence");
      expect_at(t0 + 36, K_ATK_LANES, 32'b000, "w2_pause_no_atk");
      expect_at(t0 + 36, K_ATK_PULSE, 32'd0, "w2_pause_no_pulse");
      expect_at(t0 + 40, K_STATE,     32'd1, "w2_pause_state");
      expect_at(t0 + 44, K_PRESENT,   32'b110, "w2_pres44");
      expect_at(t0 + 44, K_HEALTH,    32'b100100, "w2_pause_hit_ignored");
      expect_at(t0 + 44, K_KILL,      32'd2, "w2_kill44");
      expect_at(t0 + 45, K_PRESENT,   32'b110, "w2_pres45");
      expect_at(t0 + 54, K_PRESENT,   32'b110, "w2_pres54");
      expect_at(t0 + 55, K_PRESENT,   32'b111, "w2_pause_respawn55");
      expect_at(t0 + 55, K_HEALTH,    32'b100110, "w2_hp55");
      expect_at(t0 + 55, K_KILL,      32'd2, "w2_kill55");
      add_ev(8,  E_HIT, 0);
      add_ev(9,  E_HIT, 0);
      add_ev(29, E_HIT, 0);
      add_ev(30, E_HIT, 0);
      add_ev(32, E_HIT, 1);
      add_ev(35, E_PAUSE_ON, 0);
      add_ev(38, E_HIT, 1);
      add_ev(45, E_PAUSE_OFF, 0);
      pulse_start();
      run_events(t0);
      wait_until(t0 + 56);
      pulse_rst();

      // Wave 3: kill all nine enemies, reach CLEARED, restart.
      ht = '{7, 8, 16, 17, 24, 25, 26, 27, 33, 34, 41, 42, 43, 44, 50, 51, 60, 61};
      hl = '{0, 0, 1, 1, 0, 0, 2, 2, 1, 1, 0, 0, 2, 2, 1, 1, 2, 2};
      t0 = edge_n + 1;
      expect_at(t0,      K_STATE,   32'd1, "w3_state_run");
      expect_at(t0 + 8,  K_KILL,    32'd1, "w3_kill8");
      expect_at(t0 + 8,  K_PRESENT, 32'b000, "w3_pres8");
      expect_at(t0 + 17, K_KILL,    32'd2, "w3_kill17");
      expect_at(t0 + 23, K_PRESENT, 32'b001, "w3_pres23");
      expect_at(t0 + 23, K_HEALTH,  32'b000010, "w3_hp23");
      expect_at(t0 + 51, K_KILL,    32'd8, "w3_kill51");
      expect_at(t0 + 61, K_KILL,    32'd9, "w3_kill61");
      expect_at(t0 + 61, K_PRESENT, 32'b000, "w3_pres61");
      expect_at(t0 + 61, K_STATE,   32'd1, "w3_state61");
      expect_at(t0 + 61, K_CLEARED, 32'd0, "w3_clr61");
      expect_at(t0 + 62, K_STATE,   32'd2, "w3_state_cleared");
      expect_at(t0 + 62, K_CLEARED, 32'd1, "w3_all_cleared");
      expect_at(t0 + 63, K_STATE,   32'd2, "w3_cleared_hold");
      for (int i = 0; i < 18; i++) add_ev(ht[i], E_HIT, hl[i]);
      pulse_start();
      run_events(t0);
      wait_until(t0 + 63);

      t0 = edge_n + 1;
      expect_at(t0,      K_STATE,   32'd1, "w4_restart_run");
      expect_at(t0,      K_KILL,    32'd0, "w4_kill_cleared");
      expect_at(t0,      K_CLEARED, 32'd0, "w4_clr0");
      expect_at(t0 + 5,  K_PRESENT, 32'b000, "w4_pres5");
      expect_at(t0 + 6,  K_PRESENT, 32'b001, "w4_pres6");
      expect_at(t0 + 6,  K_HEALTH,  32'b000010, "w4_hp6");
      expect_at(t0 + 15, K_PRESENT, 32'b011, "w4_pres15");
      pulse_start();
      wait_until(t0 + 16);
      next_tick();

      check("sb_pending", sb_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
